// File: rtl/bw_r_irf_mt_winreg.sv
// bw_r_irf_mt_winreg
// Multi-threaded working register with per-thread saved register windows.
// Each hardware thread owns one WIDTH-bit working register (direct write,
// combinational read) and NWIN saved window entries. A small FSM moves data
// between a thread's working register and one of its windows:
//   save    : reg -> window, sr_done one cycle after accept
//   restore : window -> reg, sr_done two cycles after accept
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   rd_thread / rd_data       combinational read of a working register
//   wr_en/wr_thread/wr_data   direct write into a working register
//   sr_req/sr_op/sr_thread/sr_win  save(0)/restore(1) request
//   sr_busy, sr_done          FSM busy level and one-cycle completion pulse
//   sr_conflict, perr         qualifiers, only meaningful with sr_done
//
// Optional feature macro: IRF_WIN_PARITY_EN
//   defined   : window entries carry an even-parity bit, checked on restore
//   undefined : entries are WIDTH bits and perr is tied low
//
// state  | meaning
// IDLE   | waiting for sr_req
// SAVE   | writing captured register data into the window
// RD     | reading the window entry into the staging register
// COMMIT | loading staging into the working register

module bw_r_irf_mt_winreg #(
  parameter int WIDTH    = 72,
  parameter int NTHREADS = 4,
  parameter int NWIN     = 8,
  localparam int TW      = $clog2(NTHREADS),
  localparam int WW      = $clog2(NWIN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TW-1:0]    rd_thread,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [TW-1:0]    wr_thread,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             sr_req,
  input  logic             sr_op,
  input  logic [TW-1:0]    sr_thread,
  input  logic [WW-1:0]    sr_win,
  output logic             sr_busy,
  output logic             sr_done,
  output logic             sr_conflict,
  output logic             perr
);

`ifdef IRF_WIN_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, SAVE, RD, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_q [NTHREADS];
  logic [EW-1:0]    win_mem [NTHREADS*NWIN];
  logic [TW-1:0]    thr_q;
  logic [WW-1:0]    win_sel_q;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] stage_q;
  logic             accept;
  logic [TW+WW-1:0] idx;

  assign accept  = (state_q == IDLE) && sr_req;
  assign idx     = {thr_q, win_sel_q};
  assign rd_data = reg_q[rd_thread];

  // A direct write to the thread being saved in the accept cycle is what
  // gets saved, so the window never holds stale data.
  assign cap_d = (wr_en && (wr_thread == sr_thread)) ? wr_data : reg_q[sr_thread];

`ifdef IRF_WIN_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perr_q <= 1'b0;
    else if (state_q == RD)
      perr_q <= ^win_mem[idx];  // even parity over data+parity bit
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      thr_q     <= '0;
      win_sel_q <= '0;
      cap_q     <= '0;
      stage_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        thr_q     <= sr_thread;
        win_sel_q <= sr_win;
        cap_q     <= cap_d;
      end
      if (state_q == RD)
        stage_q <= win_mem[idx][WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_busy     = 1'b1;
    sr_done     = 1'b0;
    sr_conflict = 1'b0;
    perr        = 1'b0;
    case (state_q)
      IDLE: begin
        sr_busy = 1'b0;
        if (sr_req)
          state_d = sr_op ? RD : SAVE;
      end
      SAVE: begin
        sr_done = 1'b1;
        state_d = IDLE;
      end
      RD: state_d = COMMIT;
      COMMIT: begin
        sr_done     = 1'b1;
        sr_conflict = wr_en && (wr_thread == thr_q);
`ifdef IRF_WIN_PARITY_EN
        perr        = perr_q;
`endif
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Restore load is issued first so a same-thread direct write overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NTHREADS; t++)
        reg_q[t] <= '0;
    end else begin
      if (state_q == COMMIT)
        reg_q[thr_q] <= stage_q;
      if (wr_en)
        reg_q[wr_thread] <= wr_data;
    end
  end

  // Window storage has no reset; an asynchronous reset leaves state_q in
  // IDLE, which is what suppresses an interrupted save.
  always_ff @(posedge clk) begin
    if (state_q == SAVE)
`ifdef IRF_WIN_PARITY_EN
      win_mem[idx] <= {^cap_q, cap_q};
`else
      win_mem[idx] <= cap_q;
`endif
  end

endmodule

// File: tb/tb_bw_r_irf_mt_winreg.sv
module tb_bw_r_irf_mt_winreg;
  localparam int W  = 72;
  localparam int NT = 4;
  localparam int NW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   rd_thread, wr_thread, sr_thread;
  logic [2:0]   sr_win;
  logic [W-1:0] rd_data, wr_data;
  logic         wr_en, sr_req, sr_op;
  logic         sr_busy, sr_done, sr_conflict, perr;

  int checks = 0;
  int errors = 0;

  // Reference model: working registers and saved windows as plain arrays.
  logic [W-1:0] m_reg [NT];
  logic [W-1:0] m_win [NT*NW];
  bit           m_val [NT*NW];

  bw_r_irf_mt_winreg #(.WIDTH(W), .NTHREADS(NT), .NWIN(NW)) dut (
    .clk(clk), .rst(rst),
    .rd_thread(rd_thread), .rd_data(rd_data),
    .wr_en(wr_en), .wr_thread(wr_thread), .wr_data(wr_data),
    .sr_req(sr_req), .sr_op(sr_op), .sr_thread(sr_thread), .sr_win(sr_win),
    .sr_busy(sr_busy), .sr_done(sr_done), .sr_conflict(sr_conflict), .perr(perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    logic [31:0] a, b, c;
    a = $urandom(); b = $urandom(); c = $urandom();
    return {a[7:0], b, c};
  endfunction

  task automatic check_regs(input string tag);
    for (int t = 0; t < NT; t++) begin
      rd_thread = 2'(t);
      #1;
      chk(tag, rd_data, m_reg[t]);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) m_reg[t] = '0;
    for (int i = 0; i < NT*NW; i++) m_val[i] = 1'b0;
  endtask

  task automatic do_save(input logic [1:0] thr, input logic [2:0] win,
                         input logic wen, input logic [1:0] wthr, input logic [W-1:0] wdata,
                         input logic mwen, input logic [1:0] mthr, input logic [W-1:0] mdata);
    int idx;
    logic [W-1:0] cap;
    idx = int'({thr, win});
    sr_req = 1'b1; sr_op = 1'b0; sr_thread = thr; sr_win = win;
    wr_en = wen; wr_thread = wthr; wr_data = wdata;
    #1;
    chk1("save_idle_busy", sr_busy, 1'b0);
    cap = (wen && wthr == thr) ? wdata : m_reg[thr];
    if (wen) m_reg[wthr] = wdata;
    step();
    sr_op = 1'b1;  // request held while busy must be ignored
    wr_en = mwen; wr_thread = mthr; wr_data = mdata;
    #1;
    chk1("save_done", sr_done, 1'b1);
    chk1("save_busy", sr_busy, 1'b1);
    chk1("save_conflict", sr_conflict, 1'b0);
    chk1("save_perr", perr, 1'b0);
    step();
    if (mwen) m_reg[mthr] = mdata;
    m_win[idx] = cap; m_val[idx] = 1'b1;
    sr_req = 1'b0; wr_en = 1'b0;
    #1;
    chk1("save_after_done", sr_done, 1'b0);
    chk1("save_after_busy", sr_busy, 1'b0);
    check_regs("save_regs");
  endtask

  task automatic do_restore(input logic [1:0] thr, input logic [2:0] win,
                            input logic mwen, input logic [1:0] mthr, input logic [W-1:0] mdata,
                            input logic cwen, input logic [1:0] cthr, input logic [W-1:0] cdata,
                            input logic exp_perr);
    int idx;
    logic conf;
    idx = int'({thr, win});
    sr_req = 1'b1; sr_op = 1'b1; sr_thread = thr; sr_win = win; wr_en = 1'b0;
    #1;
    chk1("rst_idle_busy", sr_busy, 1'b0);
    step();
    sr_op = 1'b0;
    wr_en = mwen; wr_thread = mthr; wr_data = mdata;
    #1;
    chk1("rd_done", sr_done, 1'b0);
    chk1("rd_busy", sr_busy, 1'b1);
    step();
    if (mwen) m_reg[mthr] = mdata;
    wr_en = cwen; wr_thread = cthr; wr_data = cdata;
    conf = cwen && (cthr == thr);
    #1;
    chk1("commit_done", sr_done, 1'b1);
    chk1("commit_conflict", sr_conflict, conf);
    chk1("commit_perr", perr, exp_perr);
    step();
    if (!conf) m_reg[thr] = m_win[idx];
    if (cwen) m_reg[cthr] = cdata;
    sr_req = 1'b0; wr_en = 1'b0;
    #1;
    chk1("restore_after_done", sr_done, 1'b0);
    chk1("restore_after_busy", sr_busy, 1'b0);
    chk1("restore_after_conflict", sr_conflict, 1'b0);
    check_regs("restore_regs");
  endtask

  initial begin
    logic [1:0] t, mt, ct;
    logic [2:0] wsel;
    int idx;

    rst = 1'b1;
    rd_thread = '0; wr_en = 1'b0; wr_thread = '0; wr_data = '0;
    sr_req = 1'b0; sr_op = 1'b0; sr_thread = '0; sr_win = '0;
    model_reset();
    #2;
    chk1("reset_busy", sr_busy, 1'b0);
    chk1("reset_done", sr_done, 1'b0);
    chk1("reset_perr", perr, 1'b0);
    step(); step();
    rst = 1'b0;
    check_regs("reset_regs");

    // Direct write to thread 2
    wr_en = 1'b1; wr_thread = 2'd2; wr_data = 72'hA5;
    step();
    wr_en = 1'b0; m_reg[2] = 72'hA5;
    rd_thread = 2'd2; #1; chk("direct_rd2", rd_data, 72'hA5);
    rd_thread = 2'd0; #1; chk("direct_rd0", rd_data, 72'h0);

    // Save / overwrite / restore round trip
    wr_en = 1'b1; wr_thread = 2'd1; wr_data = 72'h11; step(); m_reg[1] = 72'h11;
    do_save(2'd1, 3'd3, 1'b0, 2'd0, '0, 1'b0, 2'd0, '0);
    wr_en = 1'b1; wr_thread = 2'd1; wr_data = 72'h22; step(); m_reg[1] = 72'h22; wr_en = 1'b0;
    do_restore(2'd1, 3'd3, 1'b0, 2'd0, '0, 1'b0, 2'd0, '0, 1'b0);
    rd_thread = 2'd1; #1; chk("roundtrip_rd1", rd_data, 72'h11);

    // Save with same-cycle direct write to the same thread
    do_save(2'd0, 3'd0, 1'b1, 2'd0, 72'h77, 1'b0, 2'd0, '0);
    wr_en = 1'b1; wr_thread = 2'd0; wr_data = 72'h0; step(); m_reg[0] = '0; wr_en = 1'b0;
    do_restore(2'd0, 3'd0, 1'b0, 2'd0, '0, 1'b0, 2'd0, '0, 1'b0);
    rd_thread = 2'd0; #1; chk("save_bypass_rd0", rd_data, 72'h77);

    // Restore conflict with direct write in COMMIT
    do_save(2'd3, 3'd2, 1'b1, 2'd3, 72'h99, 1'b0, 2'd0, '0);
    do_restore(2'd3, 3'd2, 1'b0, 2'd0, '0, 1'b1, 2'd3, 72'h55, 1'b0);
    rd_thread = 2'd3; #1; chk("conflict_rd3", rd_data, 72'h55);

    // Restore alongside a direct write to another thread
    do_restore(2'd3, 3'd2, 1'b0, 2'd0, '0, 1'b1, 2'd1, 72'h123, 1'b0);

    // Reset during RD aborts the restore
    sr_req = 1'b1; sr_op = 1'b1; sr_thread = 2'd3; sr_win = 3'd2;
    step();
    sr_req = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk1("abort_busy", sr_busy, 1'b0);
    chk1("abort_done", sr_done, 1'b0);
    rd_thread = 2'd3; #1; chk("abort_rd3", rd_data, 72'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("abort_no_done", sr_done, 1'b0);
      chk1("abort_idle", sr_busy, 1'b0);
    end
    check_regs("abort_regs");

    // Randomized mix of direct writes, saves and restores
    for (int n = 0; n < 80; n++) begin
      t = 2'($urandom_range(0, 3));
      wsel = 3'($urandom_range(0, 7));
      mt = 2'($urandom_range(0, 3));
      ct = 2'($urandom_range(0, 3));
      idx = int'({t, wsel});
      case ($urandom_range(0, 2))
        0: begin
          wr_en = 1'b1; wr_thread = mt; wr_data = rnd();
          step();
          m_reg[mt] = wr_data; wr_en = 1'b0;
          check_regs("rand_direct");
        end
        1: do_save(t, wsel, 1'($urandom_range(0, 1)), ct, rnd(),
                   1'($urandom_range(0, 1)), mt, rnd());
        default: begin
          if (m_val[idx])
            do_restore(t, wsel, 1'($urandom_range(0, 1)), mt, rnd(),
                       1'($urandom_range(0, 1)), ct, rnd(), 1'b0);
          else
            do_save(t, wsel, 1'b0, ct, '0, 1'($urandom_range(0, 1)), mt, rnd());
        end
      endcase
    end

`ifdef IRF_WIN_PARITY_EN
    // Corrupt one stored bit; restore flags perr and still loads the data
    do_save(2'd2, 3'd5, 1'b1, 2'd2, 72'h0F0F, 1'b0, 2'd0, '0);
    dut.win_mem[21][0] = ~dut.win_mem[21][0];
    m_win[21][0] = ~m_win[21][0];
    do_restore(2'd2, 3'd5, 1'b0, 2'd0, '0, 1'b0, 2'd0, '0, 1'b1);
    rd_thread = 2'd2; #1; chk("parity_rd2", rd_data, 72'h0F0E);
`else
    do_save(2'd2, 3'd5, 1'b1, 2'd2, 72'h0F0F, 1'b0, 2'd0, '0);
    do_restore(2'd2, 3'd5, 1'b0, 2'd0, '0, 1'b0, 2'd0, '0, 1'b0);
    rd_thread = 2'd2; #1; chk("noparity_rd2", rd_data, 72'h0F0F);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
